// File: rtl/tdm_scan_mux8_pkg.sv
// tdm_pkg: shared definitions for the 8-channel TDM scan transmitter.
//   state_t     - transmitter FSM states (idle, sending a frame, inter-frame gap)
//   NUM_CH      - channels per frame (one frame bit per channel)
//   SEL_W       - width of the channel select bus
//   IDLE_LEVEL  - serial line level whenever no slot is being driven
package tdm_pkg;

  localparam int   NUM_CH     = 8;
  localparam int   SEL_W      = 3;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/tdm_slot_timer.sv
// tdm_slot_timer: dwell and channel counters for one frame.
//   clk, rst    - clock, synchronous active-high reset
//   start       - frame accepted this edge; counters restart at slot 0, channel 0
//   run         - transmitter is in SEND; counters advance every cycle
//   ch          - channel currently being driven
//   slot_start  - first cycle of a channel slot
//   frame_last  - final cycle of the channel 7 slot
module tdm_slot_timer
  import tdm_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  output logic [SEL_W-1:0] ch,
  output logic             slot_start,
  output logic             frame_last
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  logic [7:0]       slot_q;
  logic [SEL_W-1:0] ch_q;
  logic             slot_end;

  assign slot_end = (slot_q == DWELL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= 8'd0;
      ch_q   <= '0;
    end else if (start) begin
      slot_q <= 8'd0;
      ch_q   <= '0;
    end else if (run) begin
      if (slot_end) begin
        slot_q <= 8'd0;
        // Wraps 7 -> 0 on the last slot; harmless since the frame ends there.
        ch_q   <= ch_q + SEL_W'(1);
      end else begin
        slot_q <= slot_q + 8'd1;
      end
    end
  end

  assign ch         = ch_q;
  assign slot_start = run && (slot_q == 8'd0);
  assign frame_last = run && slot_end && (ch_q == SEL_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_scan_mux8.sv
// tdm_scan_mux8: time-division transmitter feeding an 8-way demultiplexer.
// Accepts one 8-bit frame, then drives bit k with select k for DWELL cycles
// each, channels 0..7 in order, followed by GAP idle cycles.
//   clk, rst   - clock, synchronous active-high reset
//   iValid     - producer presents a frame
//   iData      - frame, bit k goes to channel k
//   oReady     - frame can be accepted (IDLE only)
//   oSel       - channel select {A,B,C}, A = MSB; 0 outside SEND
//   oBit       - serial data; idles at 1
//   oStrobe    - first cycle of each channel slot
//   oBusy      - frame in progress (SEND)
//   oDone      - one-cycle pulse after the last slot of a frame
//   oDbgState  - current FSM state, for observation only
//
// Handshake: a frame transfers on a rising edge where iValid && oReady are
// both 1 and rst is 0. oReady depends only on registered state, never on
// iValid; iData is captured at the transfer edge and not looked at again.
module tdm_scan_mux8
  import tdm_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iValid,
  input  logic [7:0]       iData,
  output logic             oReady,
  output logic [SEL_W-1:0] oSel,
  output logic             oBit,
  output logic             oStrobe,
  output logic             oBusy,
  output logic             oDone,
  output logic [1:0]       oDbgState
);

  localparam logic [7:0] GAP_LAST = 8'((GAP > 0) ? GAP - 1 : 0);

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       frame_q;
  logic [7:0]       gap_q;
  logic             done_q;
  logic             accept;
  logic             sending;
  logic [SEL_W-1:0] ch;
  logic             slot_start;
  logic             frame_last;

  assign accept  = (state_q == ST_IDLE) && iValid;
  assign sending = (state_q == ST_SEND);

  tdm_slot_timer #(
    .DWELL(DWELL)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .run       (sending),
    .ch        (ch),
    .slot_start(slot_start),
    .frame_last(frame_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SEND;
      ST_SEND: if (frame_last) state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:  if (gap_q == GAP_LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      frame_q <= 8'd0;
      gap_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // The pulse lands on the first cycle after channel 7, whatever the next state.
      done_q  <= frame_last;
      if (accept) frame_q <= iData;
      // Gap counter sits at 0 outside GAP so each gap starts from a clean count.
      if (state_q == ST_GAP) gap_q <= gap_q + 8'd1;
      else                   gap_q <= 8'd0;
    end
  end

  assign oReady    = (state_q == ST_IDLE);
  assign oBusy     = sending;
  assign oStrobe   = slot_start;
  assign oSel      = sending ? ch : '0;
  assign oBit      = sending ? frame_q[ch] : IDLE_LEVEL;
  assign oDone     = done_q;
  assign oDbgState = state_q;

endmodule

// File: tb/tb_tdm_scan_mux8.sv
module tb_tdm_scan_mux8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT a: DWELL=4, GAP=2
  logic       va = 1'b0;
  logic [7:0] da = 8'h00;
  logic       rdy_a, bit_a, stb_a, busy_a, done_a;
  logic [2:0] sel_a;
  logic [1:0] st_a;

  // DUT b: DWELL=1, GAP=0
  logic       vb = 1'b0;
  logic [7:0] db = 8'h00;
  logic       rdy_b, bit_b, stb_b, busy_b, done_b;
  logic [2:0] sel_b;
  logic [1:0] st_b;

  tdm_scan_mux8 #(.DWELL(4), .GAP(2)) dut_a (
    .clk(clk), .rst(rst), .iValid(va), .iData(da),
    .oReady(rdy_a), .oSel(sel_a), .oBit(bit_a), .oStrobe(stb_a),
    .oBusy(busy_a), .oDone(done_a), .oDbgState(st_a)
  );

  tdm_scan_mux8 #(.DWELL(1), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .iValid(vb), .iData(db),
    .oReady(rdy_b), .oSel(sel_b), .oBit(bit_b), .oStrobe(stb_b),
    .oBusy(busy_b), .oDone(done_b), .oDbgState(st_b)
  );

  // scoreboard: one expected output vector per cycle, {sel,bit,stb,busy,done,rdy}
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] vec(input logic [2:0] sel, input logic b,
                                     input logic stb, input logic busy,
                                     input logic done, input logic rdy);
    return {sel, b, stb, busy, done, rdy};
  endfunction

  function automatic void push_exp(input bit which, input logic [7:0] v);
    if (which) exp_b.push_back(v);
    else       exp_a.push_back(v);
  endfunction

  // Expected outputs for the cycles after the accept edge, ending with the
  // cycle in which the block is ready again.
  function automatic void push_frame(input bit which, input logic [7:0] d,
                                     input int dw, input int gp);
    int k;
    for (int j = 1; j <= 8 * dw + gp + 1; j++) begin
      if (j <= 8 * dw) begin
        k = (j - 1) / dw;
        push_exp(which, vec(3'(k), d[k], ((j - 1) % dw) == 0, 1'b1, 1'b0, 1'b0));
      end else if (j <= 8 * dw + gp) begin
        push_exp(which, vec(3'd0, 1'b1, 1'b0, 1'b0, j == 8 * dw + 1, 1'b0));
      end else begin
        push_exp(which, vec(3'd0, 1'b1, 1'b0, 1'b0, gp == 0, 1'b1));
      end
    end
  endfunction

  function automatic void push_idle(input bit which, input int n);
    for (int i = 0; i < n; i++) push_exp(which, vec(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
  endfunction

  // driver tasks: called just after an edge; the frame is accepted at the next edge
  task automatic drive_frame_a(input logic [7:0] d);
    va = 1'b1;
    da = d;
    @(posedge clk); #1;
    push_frame(1'b0, d, 4, 2);
  endtask

  task automatic drive_frame_b(input logic [7:0] d);
    vb = 1'b1;
    db = d;
    @(posedge clk); #1;
    push_frame(1'b1, d, 1, 0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // monitors
  always @(negedge clk) begin
    logic [7:0] e, a;
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      a = {sel_a, bit_a, stb_a, busy_a, done_a, rdy_a};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL dut_a_out t=%0t {sel,bit,stb,busy,done,rdy} got=%b expected=%b", $time, a, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e, a;
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      a = {sel_b, bit_b, stb_b, busy_b, done_b, rdy_b};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL dut_b_out t=%0t {sel,bit,stb,busy,done,rdy} got=%b expected=%b", $time, a, e);
      end
    end
  end

  // stimulus
  initial begin
    // reset for two edges with iValid high: must not be accepted
    rst = 1'b1;
    va  = 1'b1; da = 8'hFF;
    vb  = 1'b1; db = 8'hFF;
    step(1);
    push_idle(1'b0, 1);
    push_idle(1'b1, 1);
    step(1);
    rst = 1'b0;
    va  = 1'b0;
    vb  = 1'b0;
    push_idle(1'b0, 3);
    push_idle(1'b1, 3);
    step(2);

    // frame A5: bits 1,0,1,0,0,1,0,1; done at N+33, ready at N+35
    drive_frame_a(8'hA5);
    va = 1'b0;
    step(34);

    // frame 5A, data changes to FF mid-send with valid held; FF accepted at N+35
    drive_frame_a(8'h5A);
    da = 8'hFF;
    step(34);
    drive_frame_a(8'hFF);
    va = 1'b0;
    step(34);

    // back-to-back 01 then 80 with valid held
    drive_frame_a(8'h01);
    da = 8'h80;
    step(34);
    drive_frame_a(8'h80);
    va = 1'b0;
    step(34);

    // reset at N+10: idle from N+11 on, no done pulse afterwards
    drive_frame_a(8'hA5);
    va = 1'b0;
    step(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_a.delete();
    push_idle(1'b0, 40);
    step(39);

    // DWELL=1, GAP=0: frame 3C -> 0,0,1,1,1,1,0,0; done and ready together at N+9
    drive_frame_b(8'h3C);
    db = 8'h81;
    step(8);
    drive_frame_b(8'h81);
    vb = 1'b0;
    step(8);

    step(3);
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left_a=%0d left_b=%0d expected=0", exp_a.size(), exp_b.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_scan_mux8.md
# tdm_scan_mux8

Time-division transmitter for the 8-channel select/data link: accepts one 8-bit frame, then drives each bit in turn on a single serial line together with its 3-bit channel select. This is the sending end of the link whose receiving end is the combinational 8-way demultiplexer. That demultiplexer routes the serial bit to output `f[sel]` and holds every other output at 1. The block sits between the frame producer (valid/ready) and the select/data wires feeding the demultiplexer.

## Interface
- `DWELL`, default 4: cycles each channel slot is held; legal range 1..255.
- `GAP`, default 2: idle cycles after each frame before the next is accepted; legal range 0..255.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `iValid`  in  1  producer presents a frame.
- `iData`  in  8  frame; bit k goes to channel k.
- `oReady`  out  1  block can accept a frame; 1 only in IDLE.
- `oSel`  out  3  channel select `{A,B,C}`, where A is the MSB.
- `oBit`  out  1  serial data; idle level is 1.
- `oStrobe`  out  1  high on the first cycle of each channel slot.
- `oBusy`  out  1  high while a frame is being sent, i.e. in SEND.
- `oDone`  out  1  one-cycle pulse after the last slot of a frame.

## Operation
- States:
  - IDLE: `oReady=1`.
  - SEND: `oBusy=1`.
  - GAP: all of `oReady`, `oBusy` and `oStrobe` are 0.
- Reset values, in effect from the first edge with `rst=1`:
  - state IDLE;
  - `oSel=0`, `oBit=1`, `oStrobe=0`, `oBusy=0`, `oDone=0`;
  - `oReady=1`.
- While `rst=1`, a handshake is ignored.
- Handshake: a frame is accepted when `iValid && oReady` at an edge.
  - `iData` is captured into an internal register at that edge.
  - Later changes to `iData` have no effect on the frame being sent.
- Channel order in SEND is fixed ascending, 0 to 7.
  - `oSel` = channel index.
  - `oBit` = captured bit for that channel.
  - Slot counter: 0..DWELL-1. Channel counter: 0..7.
- After channel 7 has been held for DWELL cycles:
  - next state is GAP if `GAP>0`, otherwise IDLE;
  - `oDone=1` for exactly that first cycle.
- GAP lasts exactly GAP cycles, then the block returns to IDLE.
- Outside SEND: `oBit=1` and `oSel=0`.
- All outputs are registered or decoded from registered state. There is no combinational path from `iValid` or `iData` to any output.
- Counter widths are 8 bits for the slot and gap counters and 3 bits for the channel. No wrap-around occurs within a frame.
- Reset mid-frame: the frame is aborted and the next edge gives the reset values. No `oDone` is issued for the aborted frame.

## Timing
Frame accepted at edge N; k = 0..7:
- Channel k occupies cycles N+1+k·DWELL through N+(k+1)·DWELL.
- `oStrobe` is high at N+1+k·DWELL.
- `oDone` is high at N+8·DWELL+1.
- `oReady` returns at N+8·DWELL+GAP+1.
- Minimum frame period is 8·DWELL+GAP+1 cycles. With `iValid` held high, back-to-back frames are accepted at exactly this period.

## Structure
- Package `tdm_pkg` holds:
  - the state enum IDLE/SEND/GAP;
  - `NUM_CH=8`;
  - `SEL_W=3`;
  - `IDLE_LEVEL=1'b1`.
- Sub-module `tdm_slot_timer` contains the dwell counter and channel counter.
  - Outputs: channel index, slot-start pulse, last-slot-of-frame pulse.
- The top level contains the FSM, the capture register and the output registers.

## Test plan
- Reset: `rst=1` for 2 cycles → `oSel=0`, `oBit=1`, `oBusy=0`, `oDone=0`, `oReady=1`. An `iValid` asserted during reset is not accepted.
- DWELL=4, GAP=2, frame `8'hA5` accepted at N:
  - `oBit` per slot is 1,0,1,0,0,1,0,1;
  - `oSel` steps 0→7, changing every 4 cycles;
  - `oStrobe` is high at N+1, N+5, …, N+29;
  - `oDone` is high at N+33 only;
  - `oReady` is high again at N+35.
- Same build, frame `8'h5A` accepted, then `iData=8'hFF` with `iValid=1` held throughout the send → the line still carries 0,1,0,1,1,0,1,0. The next frame is accepted exactly at N+35.
- Same build, `rst=1` at N+10 for one cycle → reset values at N+11. No `oDone` pulse follows, and `oReady=1`.
- DWELL=1, GAP=0, frame `8'h3C` accepted at N:
  - bits 0,0,1,1,1,1,0,0 appear on N+1..N+8;
  - `oStrobe` is high every cycle of N+1..N+8;
  - `oDone` and `oReady` are both high at N+9.
- DWELL=4, GAP=2, `iValid` held high with `8'h01` then `8'h80`:
  - accepts occur at N and N+35;
  - the channel-0 slot of frame 1 carries 1, all its other slots carry 0;
  - the channel-7 slot of frame 2 carries 1;
  - `oBit=1` during both GAP cycles.
